// File: rtl/writeback_unit_pkg.sv
// Shared core package: register-file geometry, register-index type and the
// round-robin pointer encoding used by the writeback arbiter.
package writeback_unit_pkg;

    localparam int WIDTH = 32;
    localparam int NREG  = 32;
    localparam int AW    = $clog2(NREG);

    typedef logic [AW-1:0] reg_idx_t;

    typedef enum logic {
        RR_LSU_FIRST = 1'b0,
        RR_ALU_FIRST = 1'b1
    } rr_state_e;

endpackage

// File: rtl/writeback_unit_rr_arbiter2.sv
// Two-input round-robin arbiter between the ALU and LSU result ports.
// state        | meaning
// RR_LSU_FIRST | LSU wins the next contested cycle (reset value)
// RR_ALU_FIRST | ALU wins the next contested cycle
module rr_arbiter2
    import writeback_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alu_req_i,
    input  logic lsu_req_i,
    output logic alu_gnt_o,
    output logic lsu_gnt_o
);

    rr_state_e state_q, state_d;
    logic      alu_gnt, lsu_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RR_LSU_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (alu_req_i && lsu_req_i) begin
            // The pointer only moves when both sides compete.
            if (state_q == RR_LSU_FIRST) begin
                lsu_gnt = 1'b1;
                state_d = RR_ALU_FIRST;
            end else begin
                alu_gnt = 1'b1;
                state_d = RR_LSU_FIRST;
            end
        end else if (alu_req_i) begin
            alu_gnt = 1'b1;
        end else if (lsu_req_i) begin
            lsu_gnt = 1'b1;
        end
    end

    // Grants are forced low while reset is held so nothing is accepted.
    assign alu_gnt_o = alu_gnt & rst;
    assign lsu_gnt_o = lsu_gnt & rst;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU/LSU results onto one registered register-file
// write port and tracks outstanding destination writes in a pending scoreboard.
module writeback_unit #(
    parameter int WIDTH = writeback_unit_pkg::WIDTH,
    parameter int NREG  = writeback_unit_pkg::NREG,
    parameter int AW    = writeback_unit_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [WIDTH-1:0] lsu_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             flush,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [NREG-1:0]  pending
);
    import writeback_unit_pkg::*;

    logic             alu_gnt, lsu_gnt, xfer;
    logic [AW-1:0]    sel_rd;
    logic [WIDTH-1:0] sel_data;

    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]  pending_q, pending_d;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_req_i (alu_valid),
        .lsu_req_i (lsu_valid),
        .alu_gnt_o (alu_gnt),
        .lsu_gnt_o (lsu_gnt)
    );

    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;

    always_comb begin
        xfer       = alu_gnt | lsu_gnt;
        sel_rd     = lsu_gnt ? lsu_rd   : alu_rd;
        sel_data   = lsu_gnt ? lsu_data : alu_data;
        rf_we_d    = xfer && (sel_rd != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (xfer) begin
            rf_waddr_d = sel_rd;
            rf_wdata_d = sel_data;
        end
        // Clear, then set (set wins), then flush overrides everything.
        pending_d = pending_q;
        if (xfer) pending_d[sel_rd] = 1'b0;
        if (issue_valid) pending_d[issue_rd] = 1'b1;
        if (flush) pending_d = '0;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid, lsu_valid, issue_valid, flush;
    logic        alu_ready, lsu_ready, rf_we;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, rf_waddr;
    logic [31:0] alu_data, lsu_data, rf_wdata, pending;

    int nvec = 0;
    int nerr = 0;

    writeback_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
    endtask

    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];

    initial begin
        rst = 1'b0;
        idle();
        alu_rd = 5'd0; lsu_rd = 5'd0; issue_rd = 5'd0;
        alu_data = '0; lsu_data = '0;

        // Reset state, with valids high to show ready is held low
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        check("rst_rf_we",     {31'd0, rf_we},     32'd0);
        check("rst_rf_waddr",  {27'd0, rf_waddr},  32'd0);
        check("rst_rf_wdata",  rf_wdata,           32'd0);
        check("rst_pending",   pending,            32'd0);
        idle();
        @(negedge clk);
        rst = 1'b1;

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("alu_only_ready", {31'd0, alu_ready}, 32'd1);
        check("alu_only_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
        tick();
        idle();
        check("alu_only_we",    {31'd0, rf_we},    32'd1);
        check("alu_only_waddr", {27'd0, rf_waddr}, 32'd5);
        check("alu_only_wdata", rf_wdata,          32'hDEADBEEF);
        tick();
        check("idle_we_low", {31'd0, rf_we}, 32'd0);

        // Contention: LSU first after reset, then alternate
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_00A1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h0000_00B2;
        exp_addr[0] = 5'd2; exp_addr[1] = 5'd1; exp_addr[2] = 5'd2; exp_addr[3] = 5'd1;
        exp_data[0] = 32'hB2; exp_data[1] = 32'hA1; exp_data[2] = 32'hB2; exp_data[3] = 32'hA1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("contend_lsu_ready", {31'd0, lsu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("contend_alu_ready", {31'd0, alu_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            check("contend_we",    {31'd0, rf_we},    32'd1);
            check("contend_waddr", {27'd0, rf_waddr}, {27'd0, exp_addr[i]});
            check("contend_wdata", rf_wdata,          exp_data[i]);
        end
        idle();
        tick();
        check("post_contend_we", {31'd0, rf_we}, 32'd0);

        // x0 write from LSU, plus an issue to x0
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        idle();
        check("x0_we_low",   {31'd0, rf_we}, 32'd0);
        check("x0_pending0", pending,        32'd0);

        // Scoreboard: set wins over coincident clear
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle();
        check("sb_set7", pending, 32'h0000_0080);
        tick();
        tick();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        check("sb_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        alu_data = 32'h78;
        check("sb_set_wins", pending,           32'h0000_0080);
        check("sb_wr7_we",   {31'd0, rf_we},    32'd1);
        check("sb_wr7_addr", {27'd0, rf_waddr}, 32'd7);
        tick();
        idle();
        check("sb_clear7",   pending,  32'd0);
        check("sb_wr7b_data", rf_wdata, 32'h78);

        // Flush priority over issue, transfer still accepted
        for (int r = 4; r < 8; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            tick();
        end
        idle();
        check("fl_pending_f0", pending, 32'h0000_00F0);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        #1;
        check("fl_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        idle();
        check("fl_pending_0", pending,           32'd0);
        check("fl_we",        {31'd0, rf_we},    32'd1);
        check("fl_waddr",     {27'd0, rf_waddr}, 32'd6);
        check("fl_wdata",     rf_wdata,          32'h66);
        tick();

        // Move pointer away from LSU-first and set a pending bit
        alu_valid = 1'b1; alu_rd = 5'd1; lsu_valid = 1'b1; lsu_rd = 5'd2;
        issue_valid = 1'b1; issue_rd = 5'd10;
        #1;
        check("pre_rst_lsu_wins", {31'd0, lsu_ready}, 32'd1);
        tick();
        idle();
        check("pre_rst_pending", pending, 32'h0000_0400);
        // Reset in the cycle of an accepted ALU transfer
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        #1;
        check("pre_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("mid_rst_we",        {31'd0, rf_we},     32'd0);
        check("mid_rst_waddr",     {27'd0, rf_waddr},  32'd0);
        check("mid_rst_wdata",     rf_wdata,           32'd0);
        check("mid_rst_pending",   pending,            32'd0);
        tick();
        check("mid_rst_no_pulse", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB11;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC12;
        #1;
        check("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        check("post_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        idle();
        check("post_rst_we",    {31'd0, rf_we},    32'd1);
        check("post_rst_waddr", {27'd0, rf_waddr}, 32'd12);
        check("post_rst_wdata", rf_wdata,          32'hC12);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
